fpu_issue_ctrl: RTL and testbench

- Core-side initiator for the multicycle FPU.
- Accepts one FPU request per cycle from the decode stage over a valid/ready handshake and drives the FPU operand and opcode inputs for exactly one cycle per op.
- Captures the float or int result bus in the cycle the FPU produces it, and returns a tagged writeback to the register files.
- Schedules issue so no two ops ever complete in the same cycle, which keeps the FPU result muxes conflict-free.

---
 rtl/fpu_pkg.sv | 28 ++
 rtl/fpu_issue_ctrl_if.sv | 32 +++
 rtl/fpu_issue_ctrl.sv | 78 +++++++
 tb/tb_fpu_issue_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: opcode encodings and per-op scheduling helpers shared by the FPU issue logic
package fpu_pkg;
    localparam logic [3:0] OP_FADD  = 4'b0000;
    localparam logic [3:0] OP_FSUB  = 4'b0001;
    localparam logic [3:0] OP_FMUL  = 4'b0010;
    localparam logic [3:0] OP_FDIV  = 4'b0011;
    localparam logic [3:0] OP_FSQRT = 4'b0100;
    localparam logic [3:0] OP_FLOOR = 4'b0101;
    localparam logic [3:0] OP_FTOI  = 4'b0110;
    localparam logic [3:0] OP_ITOF  = 4'b0111;
    localparam logic [3:0] OP_FEQ   = 4'b1000;
    localparam logic [3:0] OP_FLESS = 4'b1001;
    localparam logic [3:0] FPU_IDLE = 4'b1111;

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_FLESS;
    endfunction

    function automatic logic is_int_result(input logic [3:0] op);
        return op == OP_FTOI || op == OP_FEQ || op == OP_FLESS;
    endfunction

    // cycles from accept to wb_valid; illegal ops retire as fast as compares
    function automatic logic [2:0] wb_latency(input logic [3:0] op);
        return (!is_legal(op) || op == OP_FEQ || op == OP_FLESS) ? 3'd1 :
               op == OP_FSQRT ? 3'd3 : op == OP_FDIV ? 3'd4 : 3'd2;
    endfunction
endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if: decode request, FPU drive/result and writeback signals of the issue controller
interface fpu_issue_ctrl_if #(parameter int TAG_W = 6);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic [3:0]       fpu_op;
    logic [31:0]      fpu_input_a;
    logic [31:0]      fpu_input_b;
    logic [31:0]      fpu_result;
    logic [31:0]      fpu_int_result;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic             wb_is_int;
    logic             wb_illegal;
    logic             busy;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, fpu_result, fpu_int_result,
        input  req_ready, fpu_op, fpu_input_a, fpu_input_b, wb_valid, wb_tag, wb_data,
               wb_is_int, wb_illegal, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, fpu_result, fpu_int_result,
        output req_ready, fpu_op, fpu_input_a, fpu_input_b, wb_valid, wb_tag, wb_data,
               wb_is_int, wb_illegal, busy
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issues decode requests to the multicycle FPU and schedules writebacks
// so no two ops ever complete in the same cycle
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int TAG_W = 6
) (
    input logic             clk,
    input logic             rst,
    fpu_issue_ctrl_if.slave io
);
    typedef struct packed {
        logic             occ;
        logic [TAG_W-1:0] tag;
        logic             is_int;
        logic             illegal;
    } slot_t;

    slot_t [4:1]      slot;
    slot_t [4:1]      slot_nxt;
    slot_t            new_slot;
    logic [7:0]       occ_v;
    logic [2:0]       lat;
    logic             legal;
    logic             accept;
    logic             issue;
    logic             now;
    logic             cap;
    logic [TAG_W-1:0] cap_tag;
    logic [31:0]      cap_data;
    logic             cap_int;
    logic             cap_ill;

    always_comb begin
        lat            = wb_latency(io.req_op);
        legal          = is_legal(io.req_op);
        occ_v          = {3'b000, slot[4].occ, slot[3].occ, slot[2].occ, slot[1].occ, 1'b0};
        io.req_ready   = ~occ_v[lat] & ~rst;
        accept         = io.req_valid & io.req_ready;
        issue          = accept & legal;
        io.fpu_op      = issue ? io.req_op : FPU_IDLE;
        io.fpu_input_a = issue ? io.req_a : '0;
        io.fpu_input_b = issue ? io.req_b : '0;
        new_slot       = {1'b1, io.req_tag, is_int_result(io.req_op), ~legal};
        slot_nxt[4]    = '0;
        for (int k = 1; k <= 3; k++)
            slot_nxt[k] = (accept && lat == 3'(k + 1)) ? new_slot : slot[k + 1];
        // a single-cycle op cannot coexist with occ[1]: its ready was gated by that slot
        now      = accept && lat == 3'd1;
        cap      = now | slot[1].occ;
        cap_tag  = now ? io.req_tag : slot[1].tag;
        cap_int  = now ? legal : slot[1].is_int;
        cap_ill  = now ? ~legal : slot[1].illegal;
        cap_data = now ? (legal ? io.fpu_int_result : '0) :
                   slot[1].is_int ? io.fpu_int_result : io.fpu_result;
        io.busy  = |occ_v | io.wb_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot          <= '0;
            io.wb_valid   <= 1'b0;
            io.wb_tag     <= '0;
            io.wb_data    <= '0;
            io.wb_is_int  <= 1'b0;
            io.wb_illegal <= 1'b0;
        end else begin
            slot        <= slot_nxt;
            io.wb_valid <= cap;
            if (cap) begin
                io.wb_tag     <= cap_tag;
                io.wb_data    <= cap_data;
                io.wb_is_int  <= cap_int;
                io.wb_illegal <= cap_ill;
            end
        end
    end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed bench with a behavioural FPU and an in-order writeback scoreboard
module tb_fpu_issue_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    fpu_issue_ctrl_if #(.TAG_W(6)) bus ();
    fpu_issue_ctrl #(.TAG_W(6)) dut (.clk(clk), .rst(rst), .io(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] data;
        logic        is_int;
        logic        illegal;
        int          at;
    } sb_t;
    sb_t sb[$];

    function automatic real s2r(input logic [31:0] x);
        logic [63:0] b;
        if (x[30:0] == 31'd0) return 0.0;
        b = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] b;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        b = $realtobits(r);
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic logic [31:0] calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        real ra, rb;
        ra = s2r(a);
        rb = s2r(b);
        case (op)
            4'd0: return r2s(ra + rb);
            4'd1: return r2s(ra - rb);
            4'd2: return r2s(ra * rb);
            4'd3: return r2s(ra / rb);
            4'd4: return r2s($sqrt(ra));
            4'd5: return r2s($floor(ra));
            4'd6: return 32'($rtoi(ra));
            4'd7: return r2s($itor($signed(a)));
            4'd8: return {31'd0, ra == rb};
            4'd9: return {31'd0, ra < rb};
            default: return 32'd0;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] op);
        return (op >= 4'd8) ? 1 : op == 4'd4 ? 3 : op == 4'd3 ? 4 : 2;
    endfunction

    function automatic int fl_delay(input logic [3:0] op);
        return (op == 4'd3) ? 3 : op == 4'd4 ? 2 :
               (op inside {4'd0, 4'd1, 4'd2, 4'd5, 4'd7}) ? 1 : 0;
    endfunction

    // behavioural FPU: newer ops overwrite older ones landing in the same cycle
    logic        fres_v [1:3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] fres_d [1:3];
    logic        ires_v = 1'b0;
    logic [31:0] ires_d;

    always @(posedge clk) begin
        int d;
        d = fl_delay(bus.fpu_op);
        fres_v[1] <= fres_v[2];
        fres_d[1] <= fres_d[2];
        fres_v[2] <= fres_v[3];
        fres_d[2] <= fres_d[3];
        fres_v[3] <= 1'b0;
        ires_v    <= bus.fpu_op == 4'd6;
        ires_d    <= calc(bus.fpu_op, bus.fpu_input_a, bus.fpu_input_b);
        if (d != 0) begin
            fres_v[d] <= 1'b1;
            fres_d[d] <= calc(bus.fpu_op, bus.fpu_input_a, bus.fpu_input_b);
        end
    end

    always_comb begin
        bus.fpu_result     = fres_v[1] ? fres_d[1] : {16'hBAD0, cyc[15:0]};
        bus.fpu_int_result = (bus.fpu_op == 4'd8 || bus.fpu_op == 4'd9) ?
                             calc(bus.fpu_op, bus.fpu_input_a, bus.fpu_input_b) :
                             ires_v ? ires_d : {16'hBAD1, cyc[15:0]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (bus.wb_valid === 1'b1) begin
            if (sb.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                check("wb_cycle", 32'(cyc), 32'(e.at));
                check("wb_tag", 32'(bus.wb_tag), 32'(e.tag));
                check("wb_data", bus.wb_data, e.data);
                check("wb_is_int", 32'(bus.wb_is_int), 32'(e.is_int));
                check("wb_illegal", 32'(bus.wb_illegal), 32'(e.illegal));
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] tag, input logic [31:0] exp, output int waits);
        sb_t e;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        #1;
        waits = 0;
        while (!bus.req_ready && waits < 10) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!bus.req_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        check("fpu_op", 32'(bus.fpu_op), 32'(op <= 4'd9 ? op : 4'hF));
        check("fpu_input_a", bus.fpu_input_a, op <= 4'd9 ? a : 32'd0);
        check("fpu_input_b", bus.fpu_input_b, op <= 4'd9 ? b : 32'd0);
        e = '{tag, exp, op inside {4'd6, 4'd8, 4'd9}, op > 4'd9, cyc + lat_of(op)};
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int w;
        logic [31:0] a;
        bus.req_valid = 1'b1;
        bus.req_op    = 4'd0;
        bus.req_a     = 32'h3F800000;
        bus.req_b     = 32'h3F800000;
        bus.req_tag   = 6'd1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst_wb_tag", 32'(bus.wb_tag), 32'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        check("rst_wb_is_int", 32'(bus.wb_is_int), 32'd0);
        check("rst_wb_illegal", 32'(bus.wb_illegal), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_fpu_op", 32'(bus.fpu_op), 32'hF);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 1'b0;
        rst = 1'b0;

        send(4'd0, 32'h3F800000, 32'h40000000, 6'd5, 32'h40400000, w);
        idle(4);

        send(4'd8, 32'h3F800000, 32'h3F800000, 6'd3, 32'd1, w);
        send(4'd9, 32'h40000000, 32'h3F800000, 6'd4, 32'd0, w);
        check("cmp_pipelined_waits", 32'(w), 32'd0);
        idle(4);

        send(4'd3, 32'h40C00000, 32'h40000000, 6'd10, 32'h40400000, w);
        check("div_waits", 32'(w), 32'd0);
        send(4'd4, 32'h40800000, 32'd0, 6'd11, 32'h40000000, w);
        check("sqrt_after_div_waits", 32'(w), 32'd1);
        idle(6);

        send(4'd6, 32'h40E00000, 32'd0, 6'd12, 32'd7, w);
        send(4'd8, 32'h40000000, 32'h40400000, 6'd13, 32'd0, w);
        check("feq_after_ftoi_waits", 32'(w), 32'd1);
        idle(4);

        for (int i = 0; i < 8; i++) begin
            a = 32'h3F800000 + (32'(i) << 20);
            send(4'd2, a, 32'h40400000, 6'(20 + i), calc(4'd2, a, 32'h40400000), w);
            check("fmul_stream_waits", 32'(w), 32'd0);
        end
        send(4'd1, 32'h40A00000, 32'h3F800000, 6'd30, 32'h40800000, w);
        send(4'd5, 32'h40500000, 32'd0, 6'd31, 32'h40400000, w);
        send(4'd7, 32'd5, 32'd0, 6'd32, 32'h40A00000, w);
        idle(5);

        send(4'd3, 32'h41000000, 32'h40000000, 6'd33, 32'h40800000, w);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 4'd0;
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(bus.req_ready), 32'd0);
        check("midrst_fpu_op", 32'(bus.fpu_op), 32'hF);
        sb.delete();
        fork
            begin
                @(negedge clk);
                rst = 1'b0;
                #1;
                check("postrst_busy", 32'(bus.busy), 32'd0);
                check("postrst_wb_valid", 32'(bus.wb_valid), 32'd0);
            end
        join_none
        send(4'd2, 32'h40000000, 32'h40400000, 6'd34, 32'h40C00000, w);
        idle(5);

        send(4'hC, 32'h12345678, 32'h9ABCDEF0, 6'd40, 32'd0, w);
        idle(1);

        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        check("final_busy", 32'(bus.busy), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
